// File: rtl/hsv_core_alu_xlen.sv
// Two-stage pipelined integer ALU with a credit-managed output FIFO.
// Results retire in acceptance order together with their opaque tag.
module hsv_core_alu_xlen #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush_req,
    output logic             flush_ack,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("hsv_core_alu_xlen: XLEN must be 32 or 64");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hsv_core_alu_xlen: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpSlt, OpSltu, OpAnd, OpOr, OpXor, OpSll,
        OpSrl, OpSra, OpRol, OpRor, OpMin, OpMax, OpMinu, OpMaxu
    } alu_op_e;

    alu_op_e            s1_op_q;
    logic [XLEN-1:0]    s1_a_q, s1_b_q;
    logic [SHW-1:0]     s1_sh_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               s1_valid_q;
    logic [XLEN-1:0]    s2_res_q;
    logic [TAG_W-1:0]   s2_tag_q;
    logic               s2_valid_q;

    logic [XLEN-1:0]    fifo_res_q [DEPTH];
    logic [TAG_W-1:0]   fifo_tag_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q, count_d;
    logic [CW:0]        occupancy;
    logic               accept, push, pop;

    logic [XLEN-1:0]    alu_res;
    logic               lt_s, lt_u;

    // Credit: every in-flight op already owns a FIFO slot, so the stages never stall.
    assign occupancy = {1'b0, count_q} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
    assign in_ready  = (occupancy < (CW+1)'(DEPTH)) && !flush_req;
    assign accept    = in_valid && in_ready;
    assign push      = s2_valid_q && !flush_req;
    assign pop       = out_valid && out_ready && !flush_req;

    assign out_valid  = (count_q != '0);
    assign out_result = fifo_res_q[rd_ptr_q];
    assign out_tag    = fifo_tag_q[rd_ptr_q];

    always_comb begin
        lt_s    = $signed(s1_a_q) < $signed(s1_b_q);
        lt_u    = s1_a_q < s1_b_q;
        alu_res = '0;
        case (s1_op_q)
            OpAdd:  alu_res = s1_a_q + s1_b_q;
            OpSub:  alu_res = s1_a_q - s1_b_q;
            OpSlt:  alu_res = XLEN'(lt_s);
            OpSltu: alu_res = XLEN'(lt_u);
            OpAnd:  alu_res = s1_a_q & s1_b_q;
            OpOr:   alu_res = s1_a_q | s1_b_q;
            OpXor:  alu_res = s1_a_q ^ s1_b_q;
            OpSll:  alu_res = s1_a_q << s1_sh_q;
            OpSrl:  alu_res = s1_a_q >> s1_sh_q;
            OpSra:  alu_res = $unsigned($signed(s1_a_q) >>> s1_sh_q);
            // A shift by XLEN yields zero, so a zero rotate amount returns the operand.
            OpRol:  alu_res = (s1_a_q << s1_sh_q) | (s1_a_q >> (XLEN - 32'(s1_sh_q)));
            OpRor:  alu_res = (s1_a_q >> s1_sh_q) | (s1_a_q << (XLEN - 32'(s1_sh_q)));
            OpMin:  alu_res = lt_s ? s1_a_q : s1_b_q;
            OpMax:  alu_res = lt_s ? s1_b_q : s1_a_q;
            OpMinu: alu_res = lt_u ? s1_a_q : s1_b_q;
            OpMaxu: alu_res = lt_u ? s1_b_q : s1_a_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            flush_ack  <= 1'b0;
        end else begin
            flush_ack <= flush_req;
            if (flush_req) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
            end else begin
                s1_valid_q <= accept;
                s2_valid_q <= s1_valid_q;
                count_q    <= count_d;
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (accept) begin
            s1_op_q  <= alu_op_e'(in_op);
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_sh_q  <= in_b[SHW-1:0];
            s1_tag_q <= in_tag;
        end
        if (s1_valid_q) begin
            s2_res_q <= alu_res;
            s2_tag_q <= s1_tag_q;
        end
        if (push) begin
            fifo_res_q[wr_ptr_q] <= s2_res_q;
            fifo_tag_q[wr_ptr_q] <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_hsv_core_alu_xlen.sv
// Scoreboard bench for hsv_core_alu_xlen: one 32-bit and one 64-bit instance.
module tb_hsv_core_alu_xlen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        fl32, fa32, iv32, rdy32, ov32, or32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32;
    logic [5:0]  tag32, otag32;
    logic [63:0] exp32;

    logic        fl64, fa64, iv64, rdy64, ov64, or64;
    logic [3:0]  op64;
    logic [63:0] a64, b64, res64;
    logic [5:0]  tag64, otag64;
    logic [63:0] exp64;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   acc32    = 0;
    bit   chk_occ  = 1'b0;

    hsv_core_alu_xlen #(.XLEN(32), .TAG_W(6), .DEPTH(4)) dut32 (
        .clk_core(clk), .rst_core(rst), .flush_req(fl32), .flush_ack(fa32),
        .in_valid(iv32), .in_ready(rdy32), .in_op(op32), .in_a(a32), .in_b(b32),
        .in_tag(tag32), .out_valid(ov32), .out_ready(or32), .out_result(res32),
        .out_tag(otag32)
    );

    hsv_core_alu_xlen #(.XLEN(64), .TAG_W(6), .DEPTH(4)) dut64 (
        .clk_core(clk), .rst_core(rst), .flush_req(fl64), .flush_ack(fa64),
        .in_valid(iv64), .in_ready(rdy64), .in_op(op64), .in_a(a64), .in_b(b64),
        .in_tag(tag64), .out_valid(ov64), .out_ready(or64), .out_result(res64),
        .out_tag(otag64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input int xl, input logic [3:0] op,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] m, a, b, r;
        logic signed [63:0] sa, sb;
        int sh;
        m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a  = a_in & m;
        b  = b_in & m;
        sa = (xl == 64) ? a : {{32{a[31]}}, a[31:0]};
        sb = (xl == 64) ? b : {{32{b[31]}}, b[31:0]};
        sh = int'(b[5:0]) & (xl - 1);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = 64'(sa < sb);
            4'd3:  r = 64'(a < b);
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = a << sh;
            4'd8:  r = a >> sh;
            4'd9:  r = sa >>> sh;
            4'd10: r = (sh == 0) ? a : ((a << sh) | (a >> (xl - sh)));
            4'd11: r = (sh == 0) ? a : ((a >> sh) | (a << (xl - sh)));
            4'd12: r = (sa < sb) ? a : b;
            4'd13: r = (sa > sb) ? a : b;
            4'd14: r = (a < b) ? a : b;
            default: r = (a > b) ? a : b;
        endcase
        return r & m;
    endfunction

    function automatic logic [63:0] rnd_operand(input int xl);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'd1 << (xl - 1);
            3: v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Inputs are set just after a falling edge; handshakes are read 1 time unit later.
    task automatic cycle();
        exp_t e;
        #1;
        if (fl32) begin
            q32.delete();
        end else begin
            if (ov32 && or32) begin
                if (q32.size() == 0) check("spurious_out32", 64'(ov32), 64'd0);
                else begin
                    e = q32.pop_front();
                    check("res32", 64'(res32), e.res);
                    check("tag32", 64'(otag32), 64'(e.tag));
                end
            end
            if (iv32 && rdy32) begin
                e.res = exp32;
                e.tag = tag32;
                q32.push_back(e);
                acc32++;
            end
        end
        if (ov64 && or64) begin
            if (q64.size() == 0) check("spurious_out64", 64'(ov64), 64'd0);
            else begin
                e = q64.pop_front();
                check("res64", res64, e.res);
                check("tag64", 64'(otag64), 64'(e.tag));
            end
        end
        if (iv64 && rdy64) begin
            e.res = exp64;
            e.tag = tag64;
            q64.push_back(e);
        end
        if (chk_occ) begin
            check("occ32", 64'(q32.size() <= 4), 64'd1);
            check("occ64", 64'(q64.size() <= 4), 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, input logic [63:0] exp);
        int guard = 0;
        iv32 = 1'b1; op32 = op; a32 = a; b32 = b; tag32 = tag; exp32 = exp;
        while (!rdy32 && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) check("accept32_timeout", 64'(rdy32), 64'd1);
        cycle();
        iv32 = 1'b0;
    endtask

    task automatic send64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] tag, input logic [63:0] exp);
        int guard = 0;
        iv64 = 1'b1; op64 = op; a64 = a; b64 = b; tag64 = tag; exp64 = exp;
        while (!rdy64 && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) check("accept64_timeout", 64'(rdy64), 64'd1);
        cycle();
        iv64 = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        iv32 = 1'b0; iv64 = 1'b0; or32 = 1'b1; or64 = 1'b1;
        while ((q32.size() != 0 || q64.size() != 0) && guard < 100) begin
            cycle();
            guard++;
        end
        check("drain_left", 64'(q32.size() + q64.size()), 64'd0);
        repeat (3) cycle();
    endtask

    task automatic rand32(input logic [5:0] tag);
        op32 = 4'($urandom_range(0, 15));
        a32 = 32'(rnd_operand(32)); b32 = 32'(rnd_operand(32)); tag32 = tag;
        exp32 = ref_alu(32, op32, 64'(a32), 64'(b32));
    endtask

    task automatic rand64(input logic [5:0] tag);
        op64 = 4'($urandom_range(0, 15));
        a64 = rnd_operand(64); b64 = rnd_operand(64); tag64 = tag;
        exp64 = ref_alu(64, op64, a64, b64);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        fl32 = 0; iv32 = 0; or32 = 0; op32 = 0; a32 = 0; b32 = 0; tag32 = 0; exp32 = 0;
        fl64 = 0; iv64 = 0; or64 = 0; op64 = 0; a64 = 0; b64 = 0; tag64 = 0; exp64 = 0;
        repeat (2) @(negedge clk);
        check("rst_ov32", 64'(ov32), 64'd0);
        check("rst_fa32", 64'(fa32), 64'd0);
        check("rst_ov64", 64'(ov64), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdy32", 64'(rdy32), 64'd1);
        check("rst_rdy64", 64'(rdy64), 64'd1);

        // Latency: accepted in cycle 0, visible in cycle 3.
        or32 = 1'b1;
        iv32 = 1'b1; op32 = 4'd0; a32 = 32'hFFFF_FFFF; b32 = 32'd1; tag32 = 6'd5; exp32 = 64'd0;
        check("lat_rdy_c0", 64'(rdy32), 64'd1);
        cycle();
        iv32 = 1'b0;
        check("lat_ov_c1", 64'(ov32), 64'd0);
        cycle();
        check("lat_ov_c2", 64'(ov32), 64'd0);
        cycle();
        check("lat_ov_c3", 64'(ov32), 64'd1);
        cycle();

        send32(4'd2, 32'hFFFF_FFFF, 32'd1, 6'd1, 64'd1);
        send32(4'd3, 32'hFFFF_FFFF, 32'd1, 6'd2, 64'd0);
        send32(4'd9, 32'h8000_0000, 32'h21, 6'd3, 64'hC000_0000);
        send32(4'd10, 32'h1234_5678, 32'h20, 6'd4, 64'h1234_5678);
        send32(4'd7, 32'd1, 32'd31, 6'd6, 64'h8000_0000);
        send32(4'd1, 32'd0, 32'd1, 6'd7, 64'hFFFF_FFFF);
        send32(4'd15, 32'h7FFF_FFFF, 32'h8000_0000, 6'd8, 64'h8000_0000);
        drain();

        send64(4'd11, 64'd1, 64'd1, 6'd9, 64'h8000_0000_0000_0000);
        send64(4'd14, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd10, 64'd0);
        send64(4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 6'd11, 64'd0);
        send64(4'd9, 64'h8000_0000_0000_0000, 64'h41, 6'd12, 64'hC000_0000_0000_0000);
        drain();

        // Backpressure: credit admits exactly DEPTH ops.
        or32 = 1'b0; acc32 = 0;
        for (int i = 0; i < 8; i++) begin
            iv32 = 1'b1;
            rand32(6'(20 + i));
            cycle();
        end
        check("bp_accepted", 64'(acc32), 64'd4);
        check("bp_rdy_full", 64'(rdy32), 64'd0);
        check("bp_ov_full", 64'(ov32), 64'd1);
        or32 = 1'b1;
        cycle();
        or32 = 1'b0;
        check("bp_rdy_after_pop", 64'(rdy32), 64'd1);
        cycle();
        drain();

        // Flush with two ops in the stages and two in the FIFO.
        or32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv32 = 1'b1;
            rand32(6'(40 + i));
            cycle();
        end
        iv32 = 1'b1; fl32 = 1'b1; or32 = 1'b1;
        check("flush_pre_ov", 64'(ov32), 64'd1);
        check("flush_rdy", 64'(rdy32), 64'd0);
        cycle();
        fl32 = 1'b0; iv32 = 1'b0;
        check("flush_ov_next", 64'(ov32), 64'd0);
        check("flush_ack_high", 64'(fa32), 64'd1);
        cycle();
        check("flush_ack_low", 64'(fa32), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("flush_pipe_empty", 64'(ov32), 64'd0);
            cycle();
        end

        // Reset in the middle of traffic discards everything.
        or32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv32 = 1'b1;
            rand32(6'(50 + i));
            cycle();
        end
        iv32 = 1'b0;
        repeat (2) cycle();
        check("mid_rst_pre_ov", 64'(ov32), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ov", 64'(ov32), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst = 1'b1;
        or32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("post_rst_ov", 64'(ov32), 64'd0);
            cycle();
        end

        // Random traffic on both widths.
        chk_occ = 1'b1;
        for (int i = 0; i < 400; i++) begin
            iv32 = ($urandom_range(0, 3) != 0);
            or32 = ($urandom_range(0, 2) != 0);
            rand32(6'(i));
            iv64 = ($urandom_range(0, 3) != 0);
            or64 = ($urandom_range(0, 1) != 0);
            rand64(6'(i + 7));
            cycle();
        end
        chk_occ = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hsv_core_alu_xlen.md
HSV_CORE_ALU_XLEN -- requirements
Module: hsv_core_alu_xlen

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter TAG_W, default 6, width of the opaque tag carried alongside each operation.
REQ-003 Parameter DEPTH, default 4, output FIFO entries; power of 2, at least 2.
REQ-004 clk_core  input  1  core clock; all state updates on the rising edge.
REQ-005 rst_core  input  1  reset, asynchronous, active-low.
REQ-006 flush_req  input  1  discard all in-flight and buffered operations.
REQ-007 flush_ack  output  1  flush acknowledge.
REQ-008 in_valid  input  1  input operation valid.
REQ-009 in_ready  output  1  block can accept the input operation.
REQ-010 in_op  input  4  opcode: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 ROL, 11 ROR, 12 MIN, 13 MAX, 14 MINU, 15 MAXU.
REQ-011 in_a, in_b  input  XLEN  operands.
REQ-012 in_tag  input  TAG_W  tag returned unchanged with the result.
REQ-013 out_valid  output  1  result available at FIFO head.
REQ-014 out_ready  input  1  consumer accepts the head result.
REQ-015 out_result  output  XLEN  head result.
REQ-016 out_tag  output  TAG_W  head tag.

Function
REQ-017 Input transfer occurs on an edge where in_valid=1 and in_ready=1; output transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-018 Pipeline: the accepting edge loads stage 1 (operand setup); the next edge loads stage 2 (add/compare/shift/rotate result); the following edge writes the FIFO. Unloaded pipe: an operation presented in cycle 0 appears at the output in cycle 3.
REQ-019 The stages never stall; space is reserved by credit: occupancy = FIFO count + stage-1 valid + stage-2 valid; in_ready = (occupancy < DEPTH) and not flush_req.
REQ-020 in_ready is derived from registered state and flush_req only, with no combinational path from out_ready or in_valid.
REQ-021 A push and a pop on the same edge leave the FIFO count unchanged; read and write pointers wrap modulo DEPTH.
REQ-022 Results leave in acceptance order; out_tag equals the in_tag of the same operation.
REQ-023 ADD and SUB are modulo 2^XLEN.
REQ-024 SLT and SLTU produce 1 if a<b (signed or unsigned respectively), else 0, zero-extended to XLEN.
REQ-025 Shift and rotate amount is in_b[log2(XLEN)-1:0]; upper bits are ignored.
REQ-026 SRA replicates in_a[XLEN-1]; a rotate by 0 returns in_a.
REQ-027 MIN, MAX, MINU and MAXU return the signed or unsigned minimum or maximum of a and b.
REQ-028 Logical ops operate bitwise on a and b.
REQ-029 out_valid = FIFO not empty; out_result and out_tag show the head entry and are don't-care while out_valid=0.
REQ-030 On an edge with flush_req=1: stage valids clear, FIFO count and pointers return to 0, no push or pop takes effect, and flush takes priority over a simultaneous input or output handshake.
REQ-031 flush_ack is flush_req registered by one cycle.
REQ-032 Illegal XLEN or DEPTH values are rejected at elaboration with an error.

Reset
REQ-033 While rst_core=0: stage valids=0, FIFO count=0, pointers=0, flush_ack=0, out_valid=0, and in_ready=1 after the reset release edge.
REQ-034 Data registers are not reset.
REQ-035 Reset asserted mid-operation discards all in-flight and buffered results, with no output transfer afterwards for those results.

Verification
REQ-036 XLEN=32, out_ready=1: ADD a=0xFFFFFFFF, b=1, tag 5 in cycle 0 -> out_valid in cycle 3, out_result=0, out_tag=5.
REQ-037 XLEN=32: SLT a=0xFFFFFFFF, b=1 -> result 1; SLTU with the same operands -> result 0; SRA a=0x80000000, b=0x21 -> result 0xC0000000.
REQ-038 XLEN=64: ROR a=1, b=1 -> result 0x8000000000000000; MINU a=0, b=-1 -> result 0; MAX a=-1, b=0 -> result 0.
REQ-039 DEPTH=4, out_ready=0, in_valid held high -> exactly 4 ops accepted, then in_ready=0; one pop -> in_ready=1 on the next cycle; tags emerge in order.
REQ-040 Flush with 2 ops in the pipe and 2 in the FIFO and simultaneous in_valid and out_ready -> nothing accepted, nothing popped, out_valid=0 next cycle, flush_ack high one cycle later.
REQ-041 Random ops with random in_valid and out_ready against a reference model -> all results and tags match in order, and occupancy never exceeds DEPTH.
